ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the attached keyboard over the same open-drain PS2_CLK/PS2_DATA pair that the keyboard receive path listens on. It performs the clock-inhibit / request-to-send sequence, shifts data on device-generated clock edges, and checks the device acknowledge bit. Outputs are open-drain enables; the top level ties each line to 0 when its enable is high and to Z otherwise.

---
 rtl/ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Runs the clock-inhibit / request-to-send handshake, shifts one command
// byte out on device-generated clock falls, and checks the device ACK bit.
// Line outputs are open-drain enables: 1 pulls the line low.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BIT_W   = 4;
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(9);
    localparam logic [CNT_W-1:0] INHIBIT_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_REQ       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_clk_s1;
    logic               r_clk_s2;
    logic               r_clk_prev;
    logic               r_data_s1;
    logic               r_data_s2;

    logic [FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_ack_err;
    logic               r_clk_oe;
    logic               r_data_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [FRAME_W-1:0] w_frame_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BIT_W-1:0]   w_bit_cnt_nxt;
    logic               w_ack_err_nxt;
    logic               w_clk_oe_nxt;
    logic               w_data_oe_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic               w_fall;
    logic               w_bus_idle;
    logic               w_inhibit_done;
    logic               w_timeout;

    assign w_fall         = r_clk_prev & ~r_clk_s2;
    assign w_bus_idle     = r_clk_s2 & r_data_s2;
    assign w_inhibit_done = (r_cnt == INHIBIT_LAST);
    // A fall in the same cycle always wins over an expiring timeout.
    assign w_timeout      = (r_cnt == TIMEOUT_LAST) && !w_fall;

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_busy     = r_busy;
    assign tx_done     = r_done;
    assign tx_err      = r_err;

    // Two-flop synchronizers on both lines plus one delay stage for clock edge detect.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_i;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data_i;
            r_data_s2  <= r_data_s1;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (tx_start) w_state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                if (w_inhibit_done) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_fall && (r_bit_cnt == LAST_BIT)) w_state_nxt = S_ACK;
                else if (w_timeout)                    w_state_nxt = S_IDLE;
            end
            S_ACK: begin
                if (w_fall)         w_state_nxt = S_WAIT_IDLE;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_WAIT_IDLE: begin
                if (w_bus_idle || w_timeout) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values; line enables are computed for the state being entered.
    always_comb begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_frame_nxt   = r_frame;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ack_err_nxt = r_ack_err;
        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_frame_nxt   = {1'b1, ~^tx_data, tx_data};
                    w_cnt_nxt     = '0;
                    w_bit_cnt_nxt = '0;
                    w_ack_err_nxt = 1'b0;
                    w_clk_oe_nxt  = 1'b1;
                end
            end
            S_INHIBIT: begin
                w_clk_oe_nxt = 1'b1;
                if (w_inhibit_done) begin
                    w_data_oe_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_REQ: begin
                w_data_oe_nxt = 1'b1;
                w_cnt_nxt     = '0;
                w_bit_cnt_nxt = '0;
            end
            S_SEND: begin
                w_data_oe_nxt = r_data_oe;
                if (w_fall) begin
                    w_data_oe_nxt = ~r_frame[0];
                    w_frame_nxt   = {1'b0, r_frame[FRAME_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                    w_cnt_nxt     = '0;
                end else if (w_timeout) begin
                    w_data_oe_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    w_ack_err_nxt = r_data_s2;
                    w_cnt_nxt     = '0;
                end else if (w_timeout) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (w_bus_idle) begin
                    w_done_nxt = ~r_ack_err;
                    w_err_nxt  = r_ack_err;
                end else if (w_timeout) begin
                    w_err_nxt = 1'b1;
                end else if (w_fall) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_frame_nxt = r_frame;
            end
        endcase
    end

    // Registered outputs, frame shifter and counters.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_frame   <= '0;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_ack_err <= 1'b0;
        end else begin
            r_clk_oe  <= w_clk_oe_nxt;
            r_data_oe <= w_data_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_frame   <= w_frame_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_ack_err <= w_ack_err_nxt;
        end
    end

endmodule
